// File: rtl/hack_alu_reg_pkg.sv
// Shared types and canonical control codes for the Hack ALU.
// Optional carry/overflow flags are enabled with HACK_ALU_CARRY_EN.
package hack_alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

  localparam ctrl_t C_ZERO  = 6'b101010;
  localparam ctrl_t C_ONE   = 6'b111111;
  localparam ctrl_t C_NEG1  = 6'b111010;
  localparam ctrl_t C_X     = 6'b001100;
  localparam ctrl_t C_Y     = 6'b110000;
  localparam ctrl_t C_NOTX  = 6'b001101;
  localparam ctrl_t C_NOTY  = 6'b110001;
  localparam ctrl_t C_NEGX  = 6'b001111;
  localparam ctrl_t C_NEGY  = 6'b110011;
  localparam ctrl_t C_XP1   = 6'b011111;
  localparam ctrl_t C_YP1   = 6'b110111;
  localparam ctrl_t C_XM1   = 6'b001110;
  localparam ctrl_t C_YM1   = 6'b110010;
  localparam ctrl_t C_XPY   = 6'b000010;
  localparam ctrl_t C_XMY   = 6'b010011;
  localparam ctrl_t C_YMX   = 6'b000111;
  localparam ctrl_t C_XANDY = 6'b000000;
  localparam ctrl_t C_XORY  = 6'b010101;

endpackage

// File: rtl/hack_alu_reg_if.sv
// Operand/result bundle between the CPU operand registers and the ALU.
// co/ov are only present when HACK_ALU_CARRY_EN is defined.
interface hack_alu_reg_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             out_valid;
`ifdef HACK_ALU_CARRY_EN
  logic             co;
  logic             ov;
`endif

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no,
    input  out, zr, ng, out_valid
`ifdef HACK_ALU_CARRY_EN
    , input co, ov
`endif
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no,
    output out, zr, ng, out_valid
`ifdef HACK_ALU_CARRY_EN
    , output co, ov
`endif
  );

endinterface

// File: rtl/hack_alu_reg_core.sv
// Combinational Hack ALU datapath: zero/negate each operand, add or AND, negate.
// Carry and signed-overflow outputs exist only with HACK_ALU_CARRY_EN.
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  ctrl_t            ctrl_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zr_o,
  output logic             ng_o
`ifdef HACK_ALU_CARRY_EN
  , output logic           co_o
  , output logic           ov_o
`endif
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r;
`ifdef HACK_ALU_CARRY_EN
  logic [WIDTH:0]   sum;
`endif

  always_comb begin
    x1 = ctrl_i.zx ? '0 : x_i;
    x2 = ctrl_i.nx ? ~x1 : x1;
    y1 = ctrl_i.zy ? '0 : y_i;
    y2 = ctrl_i.ny ? ~y1 : y1;
`ifdef HACK_ALU_CARRY_EN
    sum  = {1'b0, x2} + {1'b0, y2};
    r    = ctrl_i.f ? sum[WIDTH-1:0] : (x2 & y2);
    // Flags describe the adder, so they ignore the final inversion.
    co_o = ctrl_i.f & sum[WIDTH];
    ov_o = ctrl_i.f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
`else
    r    = ctrl_i.f ? (x2 + y2) : (x2 & y2);
`endif
    res_o = ctrl_i.no ? ~r : r;
    zr_o  = (res_o == '0);
    ng_o  = res_o[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu_reg.sv
// Registered Hack ALU: samples operands on in_valid, result and flags one cycle later.
// Build with HACK_ALU_CARRY_EN to add registered co/ov outputs.
module hack_alu_reg
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  hack_alu_reg_if.slave  bus
);

  ctrl_t            ctrl;
  logic [WIDTH-1:0] res;
  logic             res_zr, res_ng;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             valid_q;

  assign ctrl = '{zx: bus.zx, nx: bus.nx, zy: bus.zy, ny: bus.ny, f: bus.f, no: bus.no};

`ifdef HACK_ALU_CARRY_EN
  logic res_co, res_ov;
  logic co_q, co_d;
  logic ov_q, ov_d;
`endif

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x_i    (bus.x),
    .y_i    (bus.y),
    .ctrl_i (ctrl),
    .res_o  (res),
    .zr_o   (res_zr),
    .ng_o   (res_ng)
`ifdef HACK_ALU_CARRY_EN
    , .co_o (res_co)
    , .ov_o (res_ov)
`endif
  );

  // Outputs hold their last result while no new operands arrive.
  always_comb begin
    out_d = bus.in_valid ? res    : out_q;
    zr_d  = bus.in_valid ? res_zr : zr_q;
    ng_d  = bus.in_valid ? res_ng : ng_q;
`ifdef HACK_ALU_CARRY_EN
    co_d  = bus.in_valid ? res_co : co_q;
    ov_d  = bus.in_valid ? res_ov : ov_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      zr_q    <= 1'b1;
      ng_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef HACK_ALU_CARRY_EN
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
`endif
    end else begin
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      valid_q <= bus.in_valid;
`ifdef HACK_ALU_CARRY_EN
      co_q    <= co_d;
      ov_q    <= ov_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.out_valid = valid_q;
`ifdef HACK_ALU_CARRY_EN
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;
`endif

endmodule

// File: tb/tb_hack_alu_reg.sv
// Directed-vector and random checks for hack_alu_reg (default or HACK_ALU_CARRY_EN build).
module tb_hack_alu_reg;
  import hack_alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hack_alu_reg_if #(.WIDTH(W)) bus ();

  hack_alu_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    ctrl_t          c;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W-1:0]   out;
    logic           zr;
    logic           ng;
    logic           co;
    logic           ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } ref_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [W-1:0] xv, input logic [W-1:0] yv);
    bus.in_valid = v;
    bus.x  = xv;
    bus.y  = yv;
    bus.zx = c.zx;
    bus.nx = c.nx;
    bus.zy = c.zy;
    bus.ny = c.ny;
    bus.f  = c.f;
    bus.no = c.no;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model uses integer arithmetic so carry/overflow come from the value range.
  function automatic ref_t ref_alu(input ctrl_t c, input logic [W-1:0] xv, input logic [W-1:0] yv);
    ref_t         o;
    logic [W-1:0] a, b, r;
    longint       us, ss;
    a = c.zx ? '0 : xv;
    if (c.nx) a = ~a;
    b = c.zy ? '0 : yv;
    if (c.ny) b = ~b;
    us = longint'(a) + longint'(b);
    ss = longint'($signed(a)) + longint'($signed(b));
    r  = c.f ? W'(us) : (a & b);
    o.res = c.no ? ~r : r;
    o.co  = c.f && (us >= (64'd1 << W));
    o.ov  = c.f && ((ss > ((64'sd1 <<< (W-1)) - 1)) || (ss < -(64'sd1 <<< (W-1))));
    return o;
  endfunction

  task automatic chk_flags(input string nm, input logic co_e, input logic ov_e);
`ifdef HACK_ALU_CARRY_EN
    chk({nm, "_co"}, 32'(bus.co), 32'(co_e));
    chk({nm, "_ov"}, 32'(bus.ov), 32'(ov_e));
`else
    if (co_e === 1'bx || ov_e === 1'bx) $display("note: unknown flag expectation in %s", nm);
`endif
  endtask

  initial begin
    ref_t   rm;
    ctrl_t  c;
    logic   v;
    logic [W-1:0] xv, yv, e_out;
    logic   e_zr, e_ng, e_co, e_ov;

    // code, x, y, out, zr, ng, co, ov (hand-computed)
    vt[0]  = '{C_XANDY, 16'd9, 16'd15, 16'd9,      1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{6'b000001, 16'd9, 16'd15, -16'sd10, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{C_XPY,   16'd9, 16'd15, 16'd24,     1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{6'b000011, 16'd9, 16'd15, -16'sd25, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{C_ZERO,  16'd9, 16'd15, 16'd0,      1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{C_ONE,   16'd9, 16'd15, 16'd1,      1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{C_NEG1,  16'd9, 16'd15, 16'hFFFF,   1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{C_XMY,   16'd9, 16'd15, -16'sd6,    1'b0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{C_YMX,   16'd9, 16'd15, 16'd6,      1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{C_XORY,  16'd9, 16'd15, 16'd15,     1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{C_XPY,   16'd32767, 16'd1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[11] = '{C_XPY,   16'hFFFF, 16'd1, 16'd0,    1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, C_ZERO, '0, '0);
    step();
    step();
    chk("rst_out",   32'(bus.out), 32'd0);
    chk("rst_zr",    32'(bus.zr), 32'd1);
    chk("rst_ng",    32'(bus.ng), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk_flags("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // Directed vectors, back-to-back.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vt[i].c, vt[i].x, vt[i].y);
      step();
      $display("vec %0d code=%b x=%0d y=%0d out=%0d zr=%0b ng=%0b vld=%0b", i, vt[i].c,
               $signed(vt[i].x), $signed(vt[i].y), $signed(bus.out), bus.zr, bus.ng, bus.out_valid);
      chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vt[i].out));
      chk($sformatf("vec%0d_zr", i),  32'(bus.zr),  32'(vt[i].zr));
      chk($sformatf("vec%0d_ng", i),  32'(bus.ng),  32'(vt[i].ng));
      chk($sformatf("vec%0d_vld", i), 32'(bus.out_valid), 32'd1);
      chk_flags($sformatf("vec%0d", i), vt[i].co, vt[i].ov);
    end

    // Full 64-code sweep at x=9, y=15.
    for (int k = 0; k < 64; k++) begin
      c = ctrl_t'(6'(k));
      drive(1'b1, c, 16'd9, 16'd15);
      step();
      rm = ref_alu(c, 16'd9, 16'd15);
      chk($sformatf("sweep%0d_out", k), 32'(bus.out), 32'(rm.res));
      chk($sformatf("sweep%0d_zr", k),  32'(bus.zr),  32'(rm.res == '0));
      chk($sformatf("sweep%0d_vld", k), 32'(bus.out_valid), 32'd1);
      chk_flags($sformatf("sweep%0d", k), rm.co, rm.ov);
    end

    // Reset beats a simultaneous valid; the dropped input never appears.
    drive(1'b1, C_NEG1, 16'd9, 16'd15);
    step();
    rst = 1'b1;
    drive(1'b1, C_XPY, 16'd9, 16'd15);
    step();
    chk("rstv_out",   32'(bus.out), 32'd0);
    chk("rstv_zr",    32'(bus.zr), 32'd1);
    chk("rstv_ng",    32'(bus.ng), 32'd0);
    chk("rstv_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, C_XPY, 16'd9, 16'd15);
    step();
    chk("rstv_drop_valid", 32'(bus.out_valid), 32'd0);
    chk("rstv_drop_out",   32'(bus.out), 32'd0);

    // Hold for three idle cycles while the operands keep changing.
    drive(1'b1, C_NEG1, 16'd9, 16'd15);
    step();
    chk("hold_first_vld", 32'(bus.out_valid), 32'd1);
    for (int h = 0; h < 3; h++) begin
      drive(1'b0, C_XPY, 16'(h + 3), 16'(h * 7));
      step();
      chk($sformatf("hold%0d_out", h), 32'(bus.out), 32'hFFFF);
      chk($sformatf("hold%0d_zr", h),  32'(bus.zr), 32'd0);
      chk($sformatf("hold%0d_ng", h),  32'(bus.ng), 32'd1);
      chk($sformatf("hold%0d_vld", h), 32'(bus.out_valid), 32'd0);
    end

    // Random operands, codes and valid gaps against the reference model.
    e_out = 16'hFFFF; e_zr = 1'b0; e_ng = 1'b1; e_co = 1'b0; e_ov = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      v  = 1'($urandom_range(0, 1));
      c  = ctrl_t'(6'($urandom_range(0, 63)));
      xv = W'($urandom);
      yv = W'($urandom);
      drive(v, c, xv, yv);
      step();
      if (v) begin
        rm    = ref_alu(c, xv, yv);
        e_out = rm.res;
        e_zr  = (rm.res == '0);
        e_ng  = rm.res[W-1];
        e_co  = rm.co;
        e_ov  = rm.ov;
      end
      chk("rnd_out", 32'(bus.out), 32'(e_out));
      chk("rnd_zr",  32'(bus.zr), 32'(e_zr));
      chk("rnd_ng",  32'(bus.ng), 32'(e_ng));
      chk("rnd_vld", 32'(bus.out_valid), 32'(v));
      chk_flags("rnd", e_co, e_ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_alu_reg.md
Name: hack_alu_reg

Overview:
- Hack-style 16-bit ALU with six control bits (zx, nx, zy, ny, f, no) that computes one of the standard Hack functions of signed operands x and y.
- Operands and controls are sampled on a valid strobe; the result and the zr/ng status flags are registered.
- Sits between the CPU operand registers and the D/A/M write-back path. One result per cycle, fixed 1-cycle latency.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement); legal values ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies x, y and the control bits this cycle.
- x  input  WIDTH  signed operand x.
- y  input  WIDTH  signed operand y.
- zx  input  1  zero x.
- nx  input  1  bitwise-negate x (after zx).
- zy  input  1  zero y.
- ny  input  1  bitwise-negate y (after zy).
- f  input  1  1: x'+y' ; 0: x'&y'.
- no  input  1  bitwise-negate the f result.
- out  output  WIDTH  registered signed result.
- zr  output  1  registered; 1 when out == 0.
- ng  output  1  registered; 1 when out is negative (MSB of out).
- out_valid  output  1  registered; high for the cycle out, zr and ng reflect a new result.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Datapath, evaluated strictly in this order:
  - x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1.
  - y1 = zy ? 0 : y; y2 = ny ? ~y1 : y1.
  - r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2).
  - res = no ? ~r : r.
- Addition wraps with no saturation. The carry out of the MSB is discarded unless the optional feature below is enabled.
- Flags: zr = (res == 0); ng = res[WIDTH-1].
- All 64 control combinations are legal; non-canonical codes still follow the datapath above.
- Timing: when in_valid = 1 at edge N, out, zr and ng hold the result from edge N+1 onward, and out_valid = 1 for exactly that cycle.
  - Back-to-back in_valid gives back-to-back results.
  - When in_valid = 0, out, zr and ng hold their previous values and out_valid = 0.
- Reset (rst = 1 at an edge): out = 0, zr = 1, ng = 0, out_valid = 0. Reset overrides a simultaneous in_valid, so that input is dropped.
- Reset asserted while a result is pending discards it; no out_valid pulse follows.
- No back-pressure: the consumer must accept every out_valid.

Optional Feature:
- Macro: HACK_ALU_CARRY_EN.
- When defined, two extra registered outputs are present, both updated under the same timing/reset rules as zr (reset value 0):
  - co (1 bit): carry out of the f=1 addition; 0 when f=0.
  - ov (1 bit): signed overflow of x2 + y2, i.e. x2 and y2 have the same sign and the sum's sign differs; 0 when f=0.
  - Both flags are taken before the no inversion.
- When undefined, co and ov do not exist as ports; out, zr and ng are identical in both builds.

Decomposition:
- Package hack_alu_pkg holds:
  - the control-word type ctrl_t (packed zx, nx, zy, ny, f, no);
  - named constants for the 18 canonical Hack functions: C_ZERO = 101010, C_ONE = 111111, C_NEG1 = 111010, C_X = 001100, C_Y = 110000, C_NOTX = 001101, C_NOTY = 110001, C_NEGX = 001111, C_NEGY = 110011, C_XP1 = 011111, C_YP1 = 110111, C_XM1 = 001110, C_YM1 = 110010, C_XPY = 000010, C_XMY = 010011, C_YMX = 000111, C_XANDY = 000000, C_XORY = 010101.
- One sub-module, hack_alu_core: purely combinational datapath producing res, zr, ng and (optionally) co/ov. The top level adds the registers and valid logic.

Test Plan:
- x=9, y=15 swept through all 64 control codes, one per cycle. Expected values (out, zr, ng on the next cycle, out_valid=1 each cycle):
  - 000000 → 9; 000001 → -10; 000010 → 24; 000011 → -25.
  - 101010 → 0 with zr=1; 111111 → 1; 111010 → -1 with ng=1.
  - 010011 → -6; 000111 → 6; 010101 → 15.
- Reset: assert rst with in_valid=1, code 000010 → next cycle out=0, zr=1, ng=0, out_valid=0; the input is dropped.
- Hold: one valid op, then in_valid=0 for 3 cycles → out/zr/ng stable, out_valid low.
- Wrap: x=32767, y=1, code 000010 → out=-32768, ng=1, zr=0; with HACK_ALU_CARRY_EN, ov=1, co=0.
- Carry: x=-1, y=1, code 000010 → out=0, zr=1; with HACK_ALU_CARRY_EN, co=1, ov=0.
- Random: 10k random x, y and codes checked against a reference model of the datapath, with in_valid toggled randomly.
